// File: rtl/load_seq.sv
// load_seq: upstream sequencer that drives a loadable up-counter through
// a programmed number of rounds, each reloading with previous value + step.
// Build option: define LOAD_SEQ_WATCHDOG_EN to enable the RUN-state watchdog
// (err_o); when undefined, err_o is tied low and RUN waits indefinitely.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start_i             : start request (sampled in IDLE only)
//   base_i, step_i      : first load value / increment between rounds
//   rounds_i            : number of loads to issue (0 = none)
//   count_i             : counter output being watched
//   load_o, load_val_o  : load strobe and value to the counter
//   busy_o, done_o      : busy from start through done; one-cycle done pulse
//   round_o             : completed round count
//   err_o               : watchdog timeout flag
module load_seq #(
    parameter int              WIDTH = 4,
    parameter logic [WIDTH-1:0] TERM = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] base_i,
    input  logic [WIDTH-1:0] step_i,
    input  logic [3:0]       rounds_i,
    input  logic [WIDTH-1:0] count_i,
    output logic             load_o,
    output logic [WIDTH-1:0] load_val_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [3:0]       round_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [3:0]       rounds_q, rounds_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic [3:0]       round_q, round_d;
    logic             load_q, busy_q, done_q;

`ifdef LOAD_SEQ_WATCHDOG_EN
    // Timeout fires on the (2^WIDTH+1)-th RUN cycle without a terminal.
    localparam logic [WIDTH:0] WD_MAX = {1'b1, {WIDTH{1'b0}}};
    logic [WIDTH:0] wd_q, wd_d;
    logic           err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        rounds_d = rounds_q;
        val_d    = val_q;
        round_d  = round_q;
`ifdef LOAD_SEQ_WATCHDOG_EN
        wd_d     = wd_q;
        err_d    = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    step_d   = step_i;
                    rounds_d = rounds_i;
                    round_d  = 4'd0;
`ifdef LOAD_SEQ_WATCHDOG_EN
                    err_d    = 1'b0;
`endif
                    if (rounds_i == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                        val_d   = base_i;
                    end
                end
            end
            S_LOAD: begin
                // count_i still shows the pre-load value here.
                state_d = S_RUN;
`ifdef LOAD_SEQ_WATCHDOG_EN
                wd_d    = '0;
`endif
            end
            S_RUN: begin
                if (count_i == TERM) begin
                    round_d = round_q + 4'd1;
                    if (round_d == rounds_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                        val_d   = val_q + step_q;
                    end
                end
`ifdef LOAD_SEQ_WATCHDOG_EN
                else if (wd_q == WD_MAX) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            step_q   <= '0;
            rounds_q <= 4'd0;
            val_q    <= '0;
            round_q  <= 4'd0;
            load_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            rounds_q <= rounds_d;
            val_q    <= val_d;
            round_q  <= round_d;
            load_q   <= (state_d == S_LOAD);
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DONE);
        end
    end

`ifdef LOAD_SEQ_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign load_o     = load_q;
    assign load_val_o = val_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign round_o    = round_q;

endmodule

// File: tb/tb_load_seq.sv
// tb_load_seq: drives load_seq against a behavioural loadable counter and
// checks every cycle of each run against timing predicted from the rules.
module tb_load_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_i;
    logic [3:0] base_i, step_i, rounds_i, count_i;
    logic       load_o;
    logic [3:0] load_val_o;
    logic       busy_o, done_o;
    logic [3:0] round_o;
    logic       err_o;

    int checks   = 0;
    int failures = 0;
    bit freeze   = 1'b0;
    logic [3:0] cnt;

    load_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .base_i     (base_i),
        .step_i     (step_i),
        .rounds_i   (rounds_i),
        .count_i    (count_i),
        .load_o     (load_o),
        .load_val_o (load_val_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .round_o    (round_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    // Loadable up-counter stage; freeze pins it at 2 for the watchdog case.
    always @(posedge clk) begin
        if (reset)       cnt <= 4'd0;
        else if (freeze) cnt <= 4'd2;
        else if (load_o) cnt <= load_val_o;
        else             cnt <= cnt + 4'd1;
    end
    assign count_i = cnt;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Model: round i loads V_i = base + i*step (mod 16) and lasts
    // 1 + (15 - V_i + 1) cycles; done follows the last round's end.
    task automatic run_check(input logic [3:0] b, input logic [3:0] s,
                             input int r, input bit hold);
        int         ld_at[$];
        logic [3:0] ld_v[$];
        int         end_at[$];
        int         t = 0;
        logic [3:0] v = b;
        bit         el;
        logic [3:0] ev;
        int         er;
        for (int i = 0; i < r; i++) begin
            ld_at.push_back(t);
            ld_v.push_back(v);
            t += 17 - int'(v);
            end_at.push_back(t);
            v = v + s;
        end
        base_i   = b;
        step_i   = s;
        rounds_i = r[3:0];
        start_i  = 1'b1;
        step();
        if (!hold) begin
            start_i  = 1'b0;
            base_i   = 4'($urandom);
            step_i   = 4'($urandom);
            rounds_i = 4'($urandom);
        end
        for (int k = 0; k <= t; k++) begin
            el = 1'b0;
            ev = 4'd0;
            er = 0;
            for (int i = 0; i < ld_at.size(); i++)
                if (ld_at[i] == k) begin
                    el = 1'b1;
                    ev = ld_v[i];
                end
            foreach (end_at[i])
                if (end_at[i] <= k) er++;
            chk($sformatf("load k=%0d", k), load_o, el);
            chk($sformatf("busy k=%0d", k), busy_o, 1);
            chk($sformatf("done k=%0d", k), done_o, k == t);
            chk($sformatf("round k=%0d", k), round_o, er);
            chk($sformatf("err k=%0d", k), err_o, 0);
            if (el) chk($sformatf("val k=%0d", k), load_val_o, ev);
            if (k < t) step();
        end
        step();
        chk("idle_busy", busy_o, 0);
        chk("idle_done", done_o, 0);
        chk("idle_load", load_o, 0);
        chk("idle_round", round_o, r);
        if (hold) begin
            step();
            chk("restart_load", load_o, 1);
            chk("restart_val", load_val_o, b);
            chk("restart_round", round_o, 0);
            start_i = 1'b0;
        end
    endtask

    initial begin
        reset    = 1'b1;
        start_i  = 1'b0;
        base_i   = 4'd0;
        step_i   = 4'd0;
        rounds_i = 4'd0;
        step();
        step();
        chk("rst_load", load_o, 0);
        chk("rst_val", load_val_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_round", round_o, 0);
        chk("rst_err", err_o, 0);
        reset = 1'b0;
        step();

        run_check(4'h0, 4'h3, 3, 1'b0);
        step();
        run_check(4'hF, 4'h1, 2, 1'b0);
        step();
        run_check(4'h5, 4'h2, 0, 1'b0);
        step();

        for (int it = 0; it < 6; it++) begin
            run_check(4'($urandom), 4'($urandom),
                      int'($urandom_range(0, 4)), 1'b0);
            step();
        end

        // start held through a run, restart, then reset in RUN.
        run_check(4'h0, 4'h1, 1, 1'b1);
        step();
        step();
        step();
        chk("mid_busy", busy_o, 1);
        reset = 1'b1;
        step();
        chk("midrst_load", load_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_round", round_o, 0);
        chk("midrst_val", load_val_o, 0);
        reset = 1'b0;
        step();
        chk("after_rst_load", load_o, 0);

        // reset wins over start in the same cycle.
        reset    = 1'b1;
        start_i  = 1'b1;
        rounds_i = 4'd2;
        step();
        chk("prio_load", load_o, 0);
        chk("prio_busy", busy_o, 0);
        reset   = 1'b0;
        start_i = 1'b0;
        step();
        chk("prio_idle", busy_o, 0);

        freeze   = 1'b1;
        base_i   = 4'h0;
        step_i   = 4'h1;
        rounds_i = 4'd1;
        start_i  = 1'b1;
        step();
        start_i = 1'b0;
`ifdef LOAD_SEQ_WATCHDOG_EN
        // 1 LOAD cycle, 17 RUN cycles, then DONE with err.
        for (int k = 0; k <= 18; k++) begin
            chk($sformatf("wd_busy k=%0d", k), busy_o, 1);
            chk($sformatf("wd_done k=%0d", k), done_o, k == 18);
            chk($sformatf("wd_err k=%0d", k), err_o, k == 18);
            if (k < 18) step();
        end
        chk("wd_round", round_o, 0);
        step();
        chk("wd_idle_busy", busy_o, 0);
        chk("wd_err_hold", err_o, 1);
        freeze = 1'b0;
        step();
        run_check(4'hC, 4'h2, 1, 1'b0);
`else
        for (int k = 0; k <= 24; k++) begin
            chk($sformatf("nowd_busy k=%0d", k), busy_o, 1);
            chk($sformatf("nowd_done k=%0d", k), done_o, 0);
            chk($sformatf("nowd_err k=%0d", k), err_o, 0);
            step();
        end
        reset  = 1'b1;
        freeze = 1'b0;
        step();
        reset = 1'b0;
        chk("nowd_rst_busy", busy_o, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_seq.md
# load_seq

Upstream sequencer for the loadable up-counter stage. On a start request it issues a series of load pulses (`load_o`/`load_val_o`) to the counter and watches the counter's output (`count_i`). Each time the counter reaches the terminal value it reloads with the previous value plus a programmable step, until a programmed number of rounds completes. It turns the counter into a self-running multi-segment timer under a single start/done handshake.

## Interface
- `WIDTH`, 4: counter / load value width.
- `TERM`, `{WIDTH{1'b1}}` (4'hF): terminal count that ends a round.
- `clk` input 1: single clock, all logic on posedge.
- `reset` input 1: synchronous, active-high.
- `start_i` input 1: start request, sampled only in IDLE.
- `base_i` input WIDTH: first load value, captured on accepted start.
- `step_i` input WIDTH: increment between rounds, captured on accepted start.
- `rounds_i` input 4: number of loads to issue, captured on accepted start; 0 means none.
- `count_i` input WIDTH: counter output (`count_o` of the counter stage).
- `load_o` output 1: load strobe to counter (`load_i`).
- `load_val_o` output WIDTH: load value to counter (`load_val_i`).
- `busy_o` output 1: high from accepted start until `done_o`, inclusive.
- `done_o` output 1: one-cycle completion pulse.
- `round_o` output 4: number of completed rounds.
- `err_o` output 1: watchdog error flag; tied 0 when the macro is undefined.

## Operation
- The FSM has four states: IDLE, LOAD, RUN, DONE. All outputs are registered.
- In IDLE with `start_i`=1:
  - capture base, step, rounds; clear `round_o`; clear `err_o`.
  - If captured rounds=0, go to DONE. Otherwise go to LOAD with `load_val_o`=base.
- LOAD lasts exactly one cycle, with `load_o`=1.
  - `count_i` is ignored in LOAD, because it still shows the stale value.
  - Next state is RUN.
- In RUN, `load_o`=0. When `count_i`==TERM:
  - `round_o`+1.
  - If the new `round_o` equals captured rounds, go to DONE.
  - Otherwise go to LOAD with `load_val_o`=`load_val_o`+step, truncated to WIDTH (wraps mod 2^WIDTH).
- DONE lasts one cycle with `done_o`=1, then returns to IDLE.
- `busy_o`=1 in LOAD, RUN and DONE.
- `start_i` is ignored outside IDLE.
- `load_val_o` holds its last value after LOAD. `round_o` holds until the next accepted start.
- Reset values: state IDLE; `load_o`, `load_val_o`, `busy_o`, `done_o`, `round_o`, `err_o` all 0.

## Timing
- Start accepted at edge E0: `load_o`=1 during cycle E0..E1, and the counter loads at E1.
- The first RUN cycle (after E1) sees `count_i`=loaded value.
- For loaded value V, a round lasts 1 LOAD cycle plus (TERM−V+1) RUN cycles, given a counter that increments by 1 per cycle.
- A loaded value equal to TERM ends the round in its first RUN cycle.
- `done_o` is asserted in the cycle after the last terminal is detected.
- Start to first `load_o` latency is 1 cycle. Start to `done_o` latency with rounds=0 is 1 cycle.
- Reset mid-operation: at the reset edge, all outputs take their reset values and any pending round is abandoned. `load_o` is low in the following cycle.
- Reset has priority over `start_i` in the same cycle.

## Configuration
- Macro: `LOAD_SEQ_WATCHDOG_EN`.
- Defined:
  - A RUN-cycle counter clears on every LOAD.
  - If RUN lasts 2^WIDTH+1 cycles without `count_i`==TERM, the FSM goes to DONE with `err_o`=1.
  - `err_o` holds until the next accepted start or reset.
- Undefined: no watchdog; RUN waits indefinitely; `err_o` is constant 0.

## Test plan
- Reset → all outputs 0. Hold `reset`=1 during RUN → `load_o`=0 and `busy_o`=0 in the next cycle.
- Bench connected to the loadable counter; base=0, step=3, rounds=3, pulse start → loads of 0, 3, 6. Rounds last 17, 14 and 11 cycles. `done_o` pulses once, `round_o`=3.
- base=4'hF, step=1, rounds=2 → loads of F, then 0 (wrap). The first round lasts 2 cycles. `done_o` follows.
- rounds=0, start → no `load_o`; `done_o` one cycle after start; `round_o`=0.
- `start_i` held high through the run → no restart while busy. A new run is accepted in the IDLE cycle after `done_o`.
- With `LOAD_SEQ_WATCHDOG_EN` defined, `count_i` forced to 4'h2 after the load → `done_o`=1 and `err_o`=1 after 17 RUN cycles. With the macro undefined, `busy_o` stays 1 and `err_o`=0.
